alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised multi-cycle integer ALU; successor to the single-cycle ALU.
//   Executes the full RV32IM integer op set: base ops in 1 cycle, MUL*/DIV*/REM* iteratively.
//   Operands enter and results leave through valid/ready handshakes.
//   Sits between decode/regfile read and writeback; the core stalls on in_ready/out_valid.
// PARAMETERS
//   WIDTH    32               operand/result width in bits (>=4)
//   SHAMT_W  $clog2(WIDTH)    shift-amount bits taken from op2[SHAMT_W-1:0]
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      opc/op1/op2 valid this cycle
//   in_ready   out  1      block accepts an op this cycle (comb: state==IDLE)
//   opc        in   5      {funct7[5], funct7[0], funct3}
//   op1        in   WIDTH  operand A (rs1)
//   op2        in   WIDTH  operand B (rs2 or immediate)
//   out_valid  out  1      res/err valid; held until out_ready
//   out_ready  in   1      consumer takes result this cycle
//   res        out  WIDTH  registered result
//   err        out  1      registered; 1 = unsupported opc (res=0)
// BEHAVIOUR
//   Opcode map: opc[4:3]=00: f3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
//     opc[4:3]=10: f3 000 sub, 101 sra; any other f3 -> err.
//     opc[4:3]=01: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
//     opc[4:3]=11 -> err. Err ops complete like base ops (1 cycle).
//   Arithmetic mod 2^WIDTH; shifts use op2[SHAMT_W-1:0] only; slt/sltu give 0/1 zero-extended.
//   FSM states: IDLE, MUL, DIV, DONE.
//     IDLE: in_ready=1. in_valid&base/err op -> compute, load res/err, -> DONE.
//       in_valid&mul op -> latch |op1|,|op2| (signedness per opc) and result sign, clear count -> MUL.
//       in_valid&div/rem op -> special-case check, else latch magnitudes -> DIV.
//     MUL: radix-2 shift-add, one op2 bit per cycle, 2*WIDTH product; after WIDTH cycles
//       negate if sign set, select low (mul) or high (mulh*) half into res -> DONE.
//     DIV: restoring divide, one quotient bit per cycle; after WIDTH cycles
//       quotient sign = sign(op1)^sign(op2), remainder sign = sign(op1) (signed ops) -> DONE.
//     DONE: out_valid=1, res/err stable; out_ready -> IDLE. No new op accepted in DONE.
//   Latency (accept edge -> first cycle of out_valid): base/err 1; mul/div/rem WIDTH+1.
//   Throughput: base op 1 per 2 cycles at best (IDLE, DONE); no pipelining.
//   Div special cases resolved in IDLE, go straight to DONE (latency 1):
//     divisor 0: div/divu -> all ones; rem/remu -> op1.
//     signed overflow (op1=MIN, op2=-1): div -> MIN; rem -> 0.
//   Inputs are sampled only on the accept edge; later changes to op1/op2/opc are ignored.
//   out_ready while out_valid=0 is ignored.
//   Reset: state=IDLE, out_valid=0, res=0, err=0, count=0; in_ready=1 in the first cycle after reset.
//   Reset mid-operation aborts it: no result is produced and in_ready=1 on the next cycle.
//   in_valid during MUL/DIV/DONE: not accepted (in_ready=0); the producer must hold it.
// TESTING
//   add 5+7: in_valid one cycle -> out_valid next cycle, res=12, err=0; sub 3-5 -> 0xFFFFFFFE.
//   sra 0x80000000 by op2=0x3F (uses 31) -> 0xFFFFFFFF; srl same -> 1; sltu 1<0xFFFFFFFF -> 1.
//   mulhu 0x10000*0x10000 -> res=1 after 33 cycles; mul same -> 0; mulh 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//   div 7/0 -> 0xFFFFFFFF, rem 7/0 -> 7, div 0x80000000/-1 -> 0x80000000 (latency 1); div -7/2 -> -3, rem -> -1.
//   Backpressure: out_ready=0 for 5 cycles in DONE -> res/out_valid held, in_ready=0; then accept.
//   rst pulse mid-DIV -> next cycle out_valid=0, in_ready=1; opc=11000 -> err=1, res=0.

Source files
------------

// File: rtl/alu_seq_if.sv
// Valid/ready bundle between operand issue and the multi-cycle ALU.
// The issuing side uses master, the ALU uses slave.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       opc;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             err;

    modport master (
        output in_valid, opc, op1, op2, out_ready,
        input  in_ready, out_valid, res, err
    );

    modport slave (
        input  in_valid, opc, op1, op2, out_ready,
        output in_ready, out_valid, res, err
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle RV32IM integer ALU: base ops finish in one cycle,
// MUL*/DIV*/REM* iterate one bit per cycle (shift-add / restoring divide).
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 err_q, err_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mc_q, mc_d;
    logic [WIDTH-1:0]     mpl_q, mpl_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic [2:0]           f3_q, f3_d;

    logic [2*WIDTH-1:0]   mul_nx, div_nx, prod;
    logic [WIDTH:0]       r_sh, r_sub;
    logic [WIDTH-1:0]     quo, rem;
    logic [2:0]           f3_in;
    logic                 sa, sb;

    function automatic logic [WIDTH-1:0] base_op(input logic alt, input logic [2:0] f3,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [SHAMT_W-1:0] sh;
        logic [WIDTH-1:0]   r;
        sh = b[SHAMT_W-1:0];
        r  = '0;
        case ({alt, f3})
            4'b0000: r = a + b;
            4'b0001: r = a << sh;
            4'b0010: r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b0011: r = {{(WIDTH-1){1'b0}}, a < b};
            4'b0100: r = a ^ b;
            4'b0101: r = a >> sh;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b1000: r = a - b;
            4'b1101: r = $signed(a) >>> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic bad_opc(input logic [1:0] grp, input logic [2:0] f3);
        return (grp == 2'b11) || ((grp == 2'b10) && (f3 != 3'b000) && (f3 != 3'b101));
    endfunction

    // Magnitude of v when treated as signed; MIN maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    always_comb begin
        mul_nx = acc_q + (mpl_q[0] ? mc_q : '0);
        r_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        r_sub  = r_sh - {1'b0, mc_q[WIDTH-1:0]};
        div_nx = r_sub[WIDTH] ? {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {r_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod   = neg_q ? -mul_nx : mul_nx;
        quo    = neg_q ? -div_nx[WIDTH-1:0] : div_nx[WIDTH-1:0];
        rem    = rneg_q ? -div_nx[2*WIDTH-1:WIDTH] : div_nx[2*WIDTH-1:WIDTH];
        f3_in  = bus.opc[2:0];
        sa     = 1'b0;
        sb     = 1'b0;

        state_d = state_q;
        count_d = count_q;
        res_d   = res_q;
        err_d   = err_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mpl_d   = mpl_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        f3_d    = f3_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.opc[4:3] == 2'b01 && !f3_in[2]) begin
                        sa      = (f3_in == 3'b001) || (f3_in == 3'b010);
                        sb      = (f3_in == 3'b001);
                        mc_d    = {{WIDTH{1'b0}}, mag(bus.op1, sa)};
                        mpl_d   = mag(bus.op2, sb);
                        acc_d   = '0;
                        neg_d   = (sa & bus.op1[WIDTH-1]) ^ (sb & bus.op2[WIDTH-1]);
                        f3_d    = f3_in;
                        count_d = '0;
                        state_d = S_MUL;
                    end else if (bus.opc[4:3] == 2'b01) begin
                        sa    = !f3_in[0];
                        f3_d  = f3_in;
                        err_d = 1'b0;
                        // Zero divisor and MIN/-1 never enter the iterative loop.
                        if (bus.op2 == '0) begin
                            res_d   = f3_in[1] ? bus.op1 : '1;
                            state_d = S_DONE;
                        end else if (sa && bus.op1 == MIN_VAL && bus.op2 == '1) begin
                            res_d   = f3_in[1] ? '0 : MIN_VAL;
                            state_d = S_DONE;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, mag(bus.op1, sa)};
                            mc_d    = {{WIDTH{1'b0}}, mag(bus.op2, sa)};
                            neg_d   = sa & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
                            rneg_d  = sa & bus.op1[WIDTH-1];
                            count_d = '0;
                            state_d = S_DIV;
                        end
                    end else begin
                        err_d   = bad_opc(bus.opc[4:3], f3_in);
                        res_d   = err_d ? '0 : base_op(bus.opc[4], f3_in, bus.op1, bus.op2);
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (count_q == LAST) begin
                    res_d   = (f3_q == 3'b000) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    acc_d   = mul_nx;
                    mc_d    = mc_q << 1;
                    mpl_d   = mpl_q >> 1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_DIV: begin
                if (count_q == LAST) begin
                    res_d   = f3_q[1] ? rem : quo;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    acc_d   = div_nx;
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        mc_q   <= mc_d;
        mpl_q  <= mpl_d;
        neg_q  <= neg_d;
        rneg_q <= rneg_d;
        f3_q   <= f3_d;
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.res       = res_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: table of directed vectors, randomized ops against a
// 64-bit reference model, and hand sequences for backpressure and reset.
module tb_alu_seq;
    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [4:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb, ua, ub;
        int          ia, ib;
        e.res = 32'h0;
        e.err = 1'b0;
        e.lat = 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (opc[4:3])
            2'b00: case (opc[2:0])
                3'd0: e.res = a + b;
                3'd1: e.res = a << b[4:0];
                3'd2: e.res = (ia < ib) ? 32'd1 : 32'd0;
                3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
                3'd4: e.res = a ^ b;
                3'd5: e.res = a >> b[4:0];
                3'd6: e.res = a | b;
                default: e.res = a & b;
            endcase
            2'b10: case (opc[2:0])
                3'd0: e.res = a - b;
                3'd5: e.res = ia >>> b[4:0];
                default: e.err = 1'b1;
            endcase
            2'b01: begin
                if (!opc[2]) begin
                    e.lat = 33;
                    case (opc[1:0])
                        2'd0: begin p = sa * sb; e.res = p[31:0]; end
                        2'd1: begin p = sa * sb; e.res = p[63:32]; end
                        2'd2: begin p = sa * ub; e.res = p[63:32]; end
                        default: begin p = ua * ub; e.res = p[63:32]; end
                    endcase
                end else if (b == 32'h0) begin
                    e.res = opc[1] ? a : 32'hFFFF_FFFF;
                end else if (!opc[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.res = opc[1] ? 32'h0 : 32'h8000_0000;
                end else begin
                    e.lat = 33;
                    case (opc[1:0])
                        2'd0: e.res = ia / ib;
                        2'd1: e.res = a / b;
                        2'd2: e.res = ia % ib;
                        default: e.res = a % b;
                    endcase
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Presents an op at a negedge and leaves right after the accepting edge,
    // scrambling the inputs so late changes would show up in the result.
    task automatic send(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_send", {63'h0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.opc      = opc;
        bus.op1      = a;
        bus.op2      = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.opc      = 5'($urandom);
        bus.op1      = $urandom;
        bus.op2      = $urandom;
    endtask

    task automatic collect(input string name, input bit consume);
        int   lat = 1;
        exp_t e;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        check({name, "_lat"}, 64'(lat), 64'(e.lat));
        check({name, "_res"}, {32'h0, bus.res}, {32'h0, e.res});
        check({name, "_err"}, {63'h0, bus.err}, {63'h0, e.err});
        if (consume) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back(vec_t'{5'b00000, 32'd5,          32'd7,          32'd12,         1'b0, 1});
        vecs.push_back(vec_t'{5'b10000, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1});
        vecs.push_back(vec_t'{5'b10101, 32'h8000_0000,  32'h3F,         32'hFFFF_FFFF,  1'b0, 1});
        vecs.push_back(vec_t'{5'b00101, 32'h8000_0000,  32'h3F,         32'h1,          1'b0, 1});
        vecs.push_back(vec_t'{5'b00011, 32'd1,          32'hFFFF_FFFF,  32'h1,          1'b0, 1});
        vecs.push_back(vec_t'{5'b00010, 32'd1,          32'hFFFF_FFFF,  32'h0,          1'b0, 1});
        vecs.push_back(vec_t'{5'b00001, 32'd1,          32'h21,         32'h2,          1'b0, 1});
        vecs.push_back(vec_t'{5'b00100, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0, 1});
        vecs.push_back(vec_t'{5'b00110, 32'hF0F0_F0F0,  32'h0F0F_0000,  32'hFFFF_F0F0,  1'b0, 1});
        vecs.push_back(vec_t'{5'b00111, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1});
        vecs.push_back(vec_t'{5'b01011, 32'h1_0000,     32'h1_0000,     32'h1,          1'b0, 33});
        vecs.push_back(vec_t'{5'b01000, 32'h1_0000,     32'h1_0000,     32'h0,          1'b0, 33});
        vecs.push_back(vec_t'{5'b01001, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1'b0, 33});
        vecs.push_back(vec_t'{5'b01010, 32'd2,          32'hFFFF_FFFF,  32'h1,          1'b0, 33});
        vecs.push_back(vec_t'{5'b01000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  1'b0, 33});
        vecs.push_back(vec_t'{5'b01001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b0, 33});
        vecs.push_back(vec_t'{5'b01100, 32'd7,          32'd0,          32'hFFFF_FFFF,  1'b0, 1});
        vecs.push_back(vec_t'{5'b01110, 32'd7,          32'd0,          32'h7,          1'b0, 1});
        vecs.push_back(vec_t'{5'b01101, 32'd7,          32'd0,          32'hFFFF_FFFF,  1'b0, 1});
        vecs.push_back(vec_t'{5'b01100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1});
        vecs.push_back(vec_t'{5'b01110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b0, 1});
        vecs.push_back(vec_t'{5'b01100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 33});
        vecs.push_back(vec_t'{5'b01110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 33});
        vecs.push_back(vec_t'{5'b01101, 32'd100,        32'd7,          32'd14,         1'b0, 33});
        vecs.push_back(vec_t'{5'b01111, 32'd100,        32'd7,          32'd2,          1'b0, 33});
        vecs.push_back(vec_t'{5'b01101, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b0, 33});
        vecs.push_back(vec_t'{5'b11000, 32'd5,          32'd7,          32'h0,          1'b1, 1});
        vecs.push_back(vec_t'{5'b10001, 32'd5,          32'd7,          32'h0,          1'b1, 1});

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opc       = 5'h0;
        bus.op1       = 32'h0;
        bus.op2       = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready",  {63'h0, bus.in_ready},  64'd1);
        check("reset_out_valid", {63'h0, bus.out_valid}, 64'd0);
        check("reset_res",       {32'h0, bus.res},       64'd0);
        check("reset_err",       {63'h0, bus.err},       64'd0);

        // out_ready while idle must not disturb anything
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_out_ready_ignored", {63'h0, bus.out_valid}, 64'd0);

        foreach (vecs[i]) begin
            sb_q.push_back(exp_t'{vecs[i].res, vecs[i].err, vecs[i].lat});
            send(vecs[i].opc, vecs[i].a, vecs[i].b);
            collect($sformatf("vec%0d_opc%05b", i, vecs[i].opc), 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  opc;
            logic [31:0] a, b;
            opc = 5'($urandom);
            if ($urandom_range(0, 1) == 1) opc[4:3] = 2'b01;
            a = pick();
            b = pick();
            sb_q.push_back(model(opc, a, b));
            send(opc, a, b);
            collect($sformatf("rnd%0d_opc%05b_%h_%h", i, opc, a, b), 1'b1);
        end

        // Backpressure: result held in DONE, a waiting op is taken only after release
        sb_q.push_back(exp_t'{32'd12, 1'b0, 1});
        send(5'b00000, 32'd5, 32'd7);
        collect("bp_add", 1'b0);
        bus.in_valid = 1'b1;
        bus.opc      = 5'b10000;
        bus.op1      = 32'd3;
        bus.op2      = 32'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid",    {63'h0, bus.out_valid}, 64'd1);
            check("bp_hold_res",      {32'h0, bus.res},       64'd12);
            check("bp_hold_in_ready", {63'h0, bus.in_ready},  64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_in_ready",  {63'h0, bus.in_ready},  64'd1);
        check("bp_release_out_valid", {63'h0, bus.out_valid}, 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        sb_q.push_back(exp_t'{32'hFFFF_FFFE, 1'b0, 1});
        collect("bp_sub", 1'b1);

        // Reset in the middle of a divide drops it
        send(5'b01100, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", {63'h0, bus.out_valid}, 64'd0);
        check("midrst_in_ready",  {63'h0, bus.in_ready},  64'd1);
        repeat (40) @(negedge clk);
        check("midrst_no_late_result", {63'h0, bus.out_valid}, 64'd0);
        sb_q.push_back(exp_t'{32'h0, 1'b1, 1});
        send(5'b11000, 32'hDEAD_BEEF, 32'h1234_5678);
        collect("post_rst_err", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
